avalon_xbar_arbiter: RTL and testbench

Per-slave arbiter that generates the `AvalonXBarMux` select word from the master requests, so that up to NUM_MASTERS Avalon masters can share NUM_SLAVES slaves. Each slave port has its own grant state machine. A grant is held for the whole transfer, including every beat of a burst, and is released after the final beat is accepted. The block sits beside `AvalonXBarMux`: its `o_MuxSel` drives `i_MuxSel`, and it observes the same master-side and slave-side Avalon signals.

---
 rtl/avalon_xbar_arbiter_pkg.sv | 26 ++
 rtl/avalon_xbar_arbiter_if.sv | 40 ++++
 rtl/avalon_xbar_arbiter_slave_arb.sv | 127 ++++++++++++
 rtl/avalon_xbar_arbiter.sv | 57 +++++
 tb/tb_avalon_xbar_arbiter.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/avalon_xbar_arbiter_pkg.sv
// Shared constants, slave FSM state and address decode helper
// for the Avalon crossbar arbiter.
package avalon_xbar_pkg;

  localparam int AV_NUM_MASTERS = 5;
  localparam int AV_NUM_SLAVES  = 5;
  localparam int AV_ADDR_W      = 30;
  localparam int AV_SEL_BITS    = 5;
  localparam int AV_BURST_W     = 8;

  localparam int MUXSEL_W = 3;
  localparam logic [MUXSEL_W-1:0] MUXSEL_IDLE =
    MUXSEL_W'(AV_NUM_MASTERS);

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } slvState_t;

  function automatic logic [AV_SEL_BITS-1:0] slaveIdx(
    input logic [AV_ADDR_W-1:0] addr
  );
    return addr[AV_ADDR_W-1 -: AV_SEL_BITS];
  endfunction

endpackage

// File: rtl/avalon_xbar_arbiter_if.sv
// Master/slave-side Avalon observation signals and mux select
// bundle shared between the crossbar arbiter and its neighbours.
interface avalon_xbar_arbiter_if
  import avalon_xbar_pkg::*;
#(
  parameter int NUM_MASTERS = AV_NUM_MASTERS,
  parameter int NUM_SLAVES  = AV_NUM_SLAVES,
  parameter int ADDR_W      = AV_ADDR_W,
  parameter int BURST_W     = AV_BURST_W
);

  logic [NUM_MASTERS*ADDR_W-1:0]  i_AVIn_Addr;
  logic [NUM_MASTERS-1:0]         i_AVIn_Read;
  logic [NUM_MASTERS-1:0]         i_AVIn_Write;
  logic [NUM_MASTERS*BURST_W-1:0] i_AVIn_BurstCount;
  logic [NUM_SLAVES-1:0]          i_AVOut_WaitRequest;
  logic [NUM_SLAVES*MUXSEL_W-1:0] o_MuxSel;
  logic [NUM_SLAVES-1:0]          o_SlaveBusy;

  modport master (
    output i_AVIn_Addr,
    output i_AVIn_Read,
    output i_AVIn_Write,
    output i_AVIn_BurstCount,
    output i_AVOut_WaitRequest,
    input  o_MuxSel,
    input  o_SlaveBusy
  );

  modport slave (
    input  i_AVIn_Addr,
    input  i_AVIn_Read,
    input  i_AVIn_Write,
    input  i_AVIn_BurstCount,
    input  i_AVOut_WaitRequest,
    output o_MuxSel,
    output o_SlaveBusy
  );

endinterface

// File: rtl/avalon_xbar_arbiter_slave_arb.sv
// Grant FSM, beat counter and latched burst length for one slave.
// AVXBAR_ARB_RR_EN selects round-robin, otherwise fixed priority.
module avalon_xbar_slave_arb
  import avalon_xbar_pkg::*;
#(
  parameter int NUM_MASTERS = AV_NUM_MASTERS,
  parameter int BURST_W     = AV_BURST_W
) (
  input  logic                       i_Clk,
  input  logic                       i_Rst_n,
  input  logic [NUM_MASTERS-1:0]     i_Req,
  input  logic [NUM_MASTERS-1:0]     i_RdWr,
  input  logic [NUM_MASTERS*BURST_W-1:0] i_BurstCount,
  input  logic                       i_WaitRequest,
  output logic [MUXSEL_W-1:0]        o_Sel,
  output logic                       o_Busy
);

  localparam logic [MUXSEL_W-1:0] SelIdle =
    MUXSEL_W'(NUM_MASTERS);

  slvState_t state, stateNxt;
  logic [MUXSEL_W-1:0] sel, selNxt;
  logic [BURST_W-1:0]  beatCnt, beatCntNxt;
  logic [BURST_W-1:0]  effLen, effLenNxt;
  logic [MUXSEL_W-1:0] winIdx;
  logic [BURST_W-1:0]  winLen;
  logic                ownerAct;

`ifdef AVXBAR_ARB_RR_EN
  logic [MUXSEL_W-1:0] rrPtr, rrPtrNxt;

  // Round-robin: first requester after the last granted master
  always_comb begin
    winIdx = SelIdle;
    for (int k = NUM_MASTERS-1; k >= 0; k--) begin
      if (i_Req[(int'(rrPtr) + 1 + k) % NUM_MASTERS])
        winIdx = MUXSEL_W'((int'(rrPtr) + 1 + k) % NUM_MASTERS);
    end
  end
`else
  // Fixed priority: lowest requesting master index wins
  always_comb begin
    winIdx = SelIdle;
    for (int m = NUM_MASTERS-1; m >= 0; m--) begin
      if (i_Req[m])
        winIdx = MUXSEL_W'(m);
    end
  end
`endif

  // Winner burst length and current owner activity
  always_comb begin
    winLen   = '0;
    ownerAct = 1'b0;
    for (int m = 0; m < NUM_MASTERS; m++) begin
      if (winIdx == MUXSEL_W'(m))
        winLen = i_BurstCount[m*BURST_W +: BURST_W];
      if (sel == MUXSEL_W'(m))
        ownerAct = i_RdWr[m];
    end
  end

  // Next-state: grant, count beats, release on last beat or abandon
  always_comb begin
    stateNxt   = state;
    selNxt     = sel;
    beatCntNxt = beatCnt;
    effLenNxt  = effLen;
`ifdef AVXBAR_ARB_RR_EN
    rrPtrNxt   = rrPtr;
`endif
    unique case (state)
      IDLE: begin
        if (|i_Req) begin
          stateNxt   = OWNED;
          selNxt     = winIdx;
          beatCntNxt = '0;
          effLenNxt  = (winLen == '0) ? BURST_W'(1) : winLen;
`ifdef AVXBAR_ARB_RR_EN
          rrPtrNxt   = winIdx;
`endif
        end
      end
      OWNED: begin
        if (ownerAct && !i_WaitRequest) begin
          if (beatCnt == effLen - BURST_W'(1)) begin
            stateNxt   = IDLE;
            selNxt     = SelIdle;
            beatCntNxt = '0;
          end else begin
            beatCntNxt = beatCnt + BURST_W'(1);
          end
        end else if (!ownerAct && beatCnt == '0) begin
          stateNxt   = IDLE;
          selNxt     = SelIdle;
          beatCntNxt = '0;
        end
      end
    endcase
  end

  // State registers, cleared asynchronously to idle
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state   <= IDLE;
      sel     <= SelIdle;
      beatCnt <= '0;
      effLen  <= BURST_W'(1);
`ifdef AVXBAR_ARB_RR_EN
      rrPtr   <= MUXSEL_W'(NUM_MASTERS-1);
`endif
    end else begin
      state   <= stateNxt;
      sel     <= selNxt;
      beatCnt <= beatCntNxt;
      effLen  <= effLenNxt;
`ifdef AVXBAR_ARB_RR_EN
      rrPtr   <= rrPtrNxt;
`endif
    end
  end

  assign o_Sel  = sel;
  assign o_Busy = (state == OWNED);

endmodule

// File: rtl/avalon_xbar_arbiter.sv
// Per-slave arbiter driving the AvalonXBarMux select word.
// Define AVXBAR_ARB_RR_EN for round-robin, else fixed priority.
module avalon_xbar_arbiter
  import avalon_xbar_pkg::*;
#(
  parameter int NUM_MASTERS = AV_NUM_MASTERS,
  parameter int NUM_SLAVES  = AV_NUM_SLAVES,
  parameter int ADDR_W      = AV_ADDR_W,
  parameter int SEL_BITS    = AV_SEL_BITS,
  parameter int BURST_W     = AV_BURST_W
) (
  input logic i_Clk,
  input logic i_Rst_n,
  avalon_xbar_arbiter_if.slave bus
);

  logic [NUM_MASTERS-1:0]         rdWr;
  logic [NUM_SLAVES*MUXSEL_W-1:0] muxSel;
  logic [NUM_SLAVES-1:0]          busy;

  // Any transfer strobe from each master
  always_comb begin
    rdWr = bus.i_AVIn_Read | bus.i_AVIn_Write;
  end

  for (genvar s = 0; s < NUM_SLAVES; s++) begin : g_slv
    logic [NUM_MASTERS-1:0] req;

    // Masters whose address field selects this slave
    always_comb begin
      req = '0;
      for (int m = 0; m < NUM_MASTERS; m++) begin
        req[m] = rdWr[m] &&
          (slaveIdx(bus.i_AVIn_Addr[m*ADDR_W +: ADDR_W])
           == SEL_BITS'(s));
      end
    end

    avalon_xbar_slave_arb #(
      .NUM_MASTERS (NUM_MASTERS),
      .BURST_W     (BURST_W)
    ) u_arb (
      .i_Clk         (i_Clk),
      .i_Rst_n       (i_Rst_n),
      .i_Req         (req),
      .i_RdWr        (rdWr),
      .i_BurstCount  (bus.i_AVIn_BurstCount),
      .i_WaitRequest (bus.i_AVOut_WaitRequest[s]),
      .o_Sel         (muxSel[s*MUXSEL_W +: MUXSEL_W]),
      .o_Busy        (busy[s])
    );
  end

  assign bus.o_MuxSel    = muxSel;
  assign bus.o_SlaveBusy = busy;

endmodule

// File: tb/tb_avalon_xbar_arbiter.sv
// Directed vectors for avalon_xbar_arbiter with hand-computed
// select and busy expectations.
module tb_avalon_xbar_arbiter;

  logic r_Clk;
  logic r_Rst_n;
  int   nVec;
  int   nMis;

  localparam logic [14:0] AllIdle = {5{3'd5}};

  avalon_xbar_arbiter_if bus ();

  avalon_xbar_arbiter dut (
    .i_Clk   (r_Clk),
    .i_Rst_n (r_Rst_n),
    .bus     (bus)
  );

  initial r_Clk = 1'b0;
  always #5 r_Clk = ~r_Clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    nVec++;
    if (got !== exp) begin
      nMis++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge r_Clk);
    #1;
  endtask

  task automatic setM(input int m, input bit rd, input bit wr,
                      input logic [29:0] addr,
                      input logic [7:0] bc);
    bus.i_AVIn_Read[m]           = rd;
    bus.i_AVIn_Write[m]          = wr;
    bus.i_AVIn_Addr[m*30 +: 30]  = addr;
    bus.i_AVIn_BurstCount[m*8 +: 8] = bc;
  endtask

  task automatic dropM(input int m);
    bus.i_AVIn_Read[m]  = 1'b0;
    bus.i_AVIn_Write[m] = 1'b0;
  endtask

  function automatic logic [2:0] selOf(input int s);
    return bus.o_MuxSel[s*3 +: 3];
  endfunction

  initial begin
    int a;
    int b;
    nVec = 0;
    nMis = 0;
    r_Rst_n = 1'b0;
    bus.i_AVIn_Addr         = '0;
    bus.i_AVIn_Read         = '0;
    bus.i_AVIn_Write        = '0;
    bus.i_AVIn_BurstCount   = '0;
    bus.i_AVOut_WaitRequest = '1;

    // reset state
    tick();
    tick();
    chk("rst_sel", bus.o_MuxSel, AllIdle);
    chk("rst_busy", bus.o_SlaveBusy, 5'h00);
    r_Rst_n = 1'b1;
    tick();
    chk("post_rst_sel", bus.o_MuxSel, AllIdle);

    // single write, M0 -> slave 0
    setM(0, 0, 1, 30'd3, 8'd1);
    tick();
    chk("sw_grant", selOf(0), 3'd0);
    chk("sw_busy", bus.o_SlaveBusy[0], 1'b1);
    bus.i_AVOut_WaitRequest[0] = 1'b0;
    tick();
    dropM(0);
    chk("sw_release", selOf(0), 3'd5);
    chk("sw_busy_off", bus.o_SlaveBusy[0], 1'b0);
    tick();
    chk("sw_stay_idle", selOf(0), 3'd5);

    // contention on slave 0
`ifdef AVXBAR_ARB_RR_EN
    a = 1;
    b = 0;
`else
    a = 0;
    b = 1;
`endif
    setM(0, 0, 1, 30'd3, 8'd1);
    setM(1, 0, 1, 30'd3, 8'd1);
    tick();
    chk("ct_first", selOf(0), 3'(a));
    tick();
    dropM(a);
    chk("ct_gap", selOf(0), 3'd5);
    tick();
    chk("ct_second", selOf(0), 3'(b));
    tick();
    dropM(b);
    chk("ct_done", selOf(0), 3'd5);

    // burst hold on slave 1
    bus.i_AVOut_WaitRequest[1] = 1'b1;
    setM(2, 1, 0, 30'h2000000, 8'd4);
    tick();
    chk("bh_grant", selOf(1), 3'd2);
    bus.i_AVOut_WaitRequest[1] = 1'b0;
    setM(0, 1, 0, 30'h2000010, 8'd1);
    tick();
    chk("bh_beat1", selOf(1), 3'd2);
    tick();
    chk("bh_beat2", selOf(1), 3'd2);
    bus.i_AVOut_WaitRequest[1] = 1'b1;
    tick();
    chk("bh_stall", selOf(1), 3'd2);
    bus.i_AVOut_WaitRequest[1] = 1'b0;
    bus.i_AVIn_Read[2] = 1'b0;
    tick();
    chk("bh_gap_hold", selOf(1), 3'd2);
    bus.i_AVIn_Read[2] = 1'b1;
    tick();
    chk("bh_beat3", selOf(1), 3'd2);
    tick();
    dropM(2);
    chk("bh_release", selOf(1), 3'd5);
    tick();
    chk("bh_next", selOf(1), 3'd0);
    tick();
    dropM(0);
    chk("bh_next_done", selOf(1), 3'd5);

    // parallel slaves, then abandon both
    bus.i_AVOut_WaitRequest = '1;
    setM(0, 0, 1, 30'h2000003, 8'd1);
    setM(1, 0, 1, 30'd3, 8'd1);
    tick();
    chk("par_sel1", selOf(1), 3'd0);
    chk("par_sel0", selOf(0), 3'd1);
    dropM(0);
    dropM(1);
    tick();
    chk("par_abandon", bus.o_MuxSel, AllIdle);

    // abandon on slave 2
    setM(3, 0, 1, 30'h4000000, 8'd2);
    tick();
    chk("ab_grant", selOf(2), 3'd3);
    chk("ab_busy", bus.o_SlaveBusy, 5'h04);
    dropM(3);
    tick();
    chk("ab_release", selOf(2), 3'd5);
    chk("ab_busy_off", bus.o_SlaveBusy, 5'h00);

    // unmapped field 7 alongside real traffic
    setM(4, 0, 1, 30'h0E000000, 8'd1);
    setM(1, 1, 0, 30'h4000000, 8'd1);
    bus.i_AVOut_WaitRequest[2] = 1'b0;
    tick();
    chk("um_traffic", bus.o_MuxSel,
        {3'd5, 3'd5, 3'd1, 3'd5, 3'd5});
    tick();
    dropM(1);
    chk("um_release", bus.o_MuxSel, AllIdle);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("um_never", bus.o_MuxSel, AllIdle);
    end
    dropM(4);

    // slave 4: last grant M1, then M0 and M1 collide
    bus.i_AVOut_WaitRequest[4] = 1'b0;
    setM(1, 0, 1, 30'h8000000, 8'd1);
    tick();
    chk("rr_pre", selOf(4), 3'd1);
    tick();
    dropM(1);
    chk("rr_pre_done", selOf(4), 3'd5);
    setM(0, 0, 1, 30'h8000000, 8'd0);
    setM(1, 0, 1, 30'h8000000, 8'd1);
    tick();
    chk("rr_first", selOf(4), 3'd0);
    tick();
    dropM(0);
    chk("rr_len0", selOf(4), 3'd5);
    tick();
    chk("rr_second", selOf(4), 3'd1);
    tick();
    dropM(1);
    chk("rr_done", selOf(4), 3'd5);

    // async reset mid-burst on slave 3
    bus.i_AVOut_WaitRequest[3] = 1'b0;
    setM(2, 1, 0, 30'h6000000, 8'd4);
    tick();
    chk("rs_grant", selOf(3), 3'd2);
    tick();
    chk("rs_beat1", selOf(3), 3'd2);
    #2;
    r_Rst_n = 1'b0;
    #1;
    chk("rs_async_sel", bus.o_MuxSel, AllIdle);
    chk("rs_async_busy", bus.o_SlaveBusy, 5'h00);
    dropM(2);
    tick();
    r_Rst_n = 1'b1;
    tick();
    chk("rs_after", bus.o_MuxSel, AllIdle);

    $display("== %0d vectors applied, %0d miscompares ==",
             nVec, nMis);
    $finish;
  end

endmodule
